// File: rtl/rps_game_ctrl_pkg.sv
// rps_game_ctrl_pkg: state encoding, display selector codes and choice codes for the RPS controller
package rps_game_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_SHOW_PLAYER, ST_SHOW_RIVAL_LBL, ST_SHOW_RIVAL, ST_RESULT
  } state_e;
  localparam logic [3:0] SEL_START    = 4'd0;
  localparam logic [3:0] SEL_SELECT   = 4'd1;
  localparam logic [3:0] SEL_PAPER    = 4'd2;
  localparam logic [3:0] SEL_SCISSORS = 4'd3;
  localparam logic [3:0] SEL_ROCK     = 4'd4;
  localparam logic [3:0] SEL_RIVAL    = 4'd5;
  localparam logic [3:0] SEL_WON      = 4'd6;
  localparam logic [3:0] SEL_LOST     = 4'd7;
  localparam logic [3:0] SEL_TIE      = 4'd8;
  localparam logic [1:0] CH_ROCK      = 2'd0;
  localparam logic [1:0] CH_PAPER     = 2'd1;
  localparam logic [1:0] CH_SCISSORS  = 2'd2;
  function automatic logic [3:0] ch_sel(input logic [1:0] ch);
    return ch == CH_ROCK ? SEL_ROCK : ch == CH_PAPER ? SEL_PAPER : SEL_SCISSORS;
  endfunction
  // the choice that defeats ch: the next one in rock -> paper -> scissors -> rock order
  function automatic logic [1:0] beats(input logic [1:0] ch);
    return ch == CH_SCISSORS ? CH_ROCK : ch + 2'd1;
  endfunction
endpackage

// File: rtl/rps_game_ctrl_if.sv
// rps_game_ctrl_if: player buttons in, display selector and tallies out
interface rps_game_ctrl_if;
  logic       btn_start;
  logic       btn_rock;
  logic       btn_paper;
  logic       btn_scissors;
  logic [3:0] selector;
  logic [3:0] wins;
  logic [3:0] losses;
  logic       round_done;
  modport master (output btn_start, btn_rock, btn_paper, btn_scissors,
                  input selector, wins, losses, round_done);
  modport slave  (input btn_start, btn_rock, btn_paper, btn_scissors,
                  output selector, wins, losses, round_done);
endinterface

// File: rtl/rps_game_ctrl_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer with rising-edge press detection
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic press_o
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1_q, s2_q, prev_q} <= '0;
    else        {s1_q, s2_q, prev_q} <= {pin_i, s1_q, s2_q};
  assign press_o = s2_q & ~prev_q;
endmodule

// File: rtl/rps_game_ctrl.sv
// rps_game_ctrl: rock-paper-scissors round sequencer driving the text display selector
module rps_game_ctrl
  import rps_game_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input logic clk,
  input logic reset,
  rps_game_ctrl_if.slave bus
);
  logic p_start, p_rock, p_paper, p_sc;
  btn_sync_edge u_start (.clk(clk), .reset(reset), .pin_i(bus.btn_start),    .press_o(p_start));
  btn_sync_edge u_rock  (.clk(clk), .reset(reset), .pin_i(bus.btn_rock),     .press_o(p_rock));
  btn_sync_edge u_paper (.clk(clk), .reset(reset), .pin_i(bus.btn_paper),    .press_o(p_paper));
  btn_sync_edge u_sc    (.clk(clk), .reset(reset), .pin_i(bus.btn_scissors), .press_o(p_sc));
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       rival_cnt_q, player_q, player_d, rival_q, rival_d;
  logic [3:0]       sel_q, sel_d, wins_q, wins_d, losses_q, losses_d;
  logic             done_q, done_d, hold_done, one_choice, win, tie;
  always_comb begin
    hold_done  = timer_q == CNT_W'(HOLD_CYCLES - 1);
    one_choice = {p_rock, p_paper, p_sc} inside {3'b100, 3'b010, 3'b001};
    win        = player_q == beats(rival_q);
    tie        = player_q == rival_q;
    state_d    = state_q;
    player_d   = player_q;
    rival_d    = rival_q;
    wins_d     = wins_q;
    losses_d   = losses_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE:           state_d = p_start ? ST_SELECT : ST_IDLE;
      ST_SELECT: if (one_choice) begin
        state_d  = ST_SHOW_PLAYER;
        player_d = p_rock ? CH_ROCK : p_paper ? CH_PAPER : CH_SCISSORS;
        rival_d  = rival_cnt_q;
      end
      ST_SHOW_PLAYER:    state_d = hold_done ? ST_SHOW_RIVAL_LBL : state_q;
      ST_SHOW_RIVAL_LBL: state_d = hold_done ? ST_SHOW_RIVAL : state_q;
      ST_SHOW_RIVAL: if (hold_done) begin
        state_d  = ST_RESULT;
        done_d   = 1'b1;
        wins_d   = (win && !(&wins_q)) ? wins_q + 4'd1 : wins_q;
        losses_d = (!win && !tie && !(&losses_q)) ? losses_q + 4'd1 : losses_q;
      end
      ST_RESULT:         state_d = p_start ? ST_SELECT : ST_RESULT;
      default:           state_d = ST_IDLE;
    endcase
    timer_d = state_d != state_q ? '0 : timer_q + 1'b1;
    // selector is registered from the next state so it changes on the same edge as the state
    sel_d = state_d == ST_IDLE           ? SEL_START :
            state_d == ST_SELECT         ? SEL_SELECT :
            state_d == ST_SHOW_PLAYER    ? ch_sel(player_d) :
            state_d == ST_SHOW_RIVAL_LBL ? SEL_RIVAL :
            state_d == ST_SHOW_RIVAL     ? ch_sel(rival_d) :
            win ? SEL_WON : tie ? SEL_TIE : SEL_LOST;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      rival_cnt_q <= '0;
      player_q    <= '0;
      rival_q     <= '0;
      sel_q       <= SEL_START;
      wins_q      <= '0;
      losses_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rival_cnt_q <= rival_cnt_q == 2'd2 ? 2'd0 : rival_cnt_q + 2'd1;
      player_q    <= player_d;
      rival_q     <= rival_d;
      sel_q       <= sel_d;
      wins_q      <= wins_d;
      losses_q    <= losses_d;
      done_q      <= done_d;
    end
  assign bus.selector   = sel_q;
  assign bus.wins       = wins_q;
  assign bus.losses     = losses_q;
  assign bus.round_done = done_q;
endmodule

// File: tb/tb_rps_game_ctrl.sv
// tb_rps_game_ctrl: directed round table plus hand sequences for reset, saturation and discarded presses
module tb_rps_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [1:0] rc;
  rps_game_ctrl_if bus ();
  rps_game_ctrl #(.HOLD_CYCLES(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rc <= 2'd0;
    else        rc <= rc == 2'd2 ? 2'd0 : rc + 2'd1;

  typedef struct {
    int choice;
    int rival;
    int exp_p;
    int exp_r;
    int exp_res;
    int exp_w;
    int exp_l;
  } rnd_t;
  rnd_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_choice(input int ch, input logic v);
    if (ch == 0) bus.btn_rock = v;
    else if (ch == 1) bus.btn_paper = v;
    else bus.btn_scissors = v;
  endtask

  task automatic press_at_rival(input int ch, input int rival);
    int g = 0;
    while (int'(rc) != (rival + 1) % 3 && g < 5) begin
      @(negedge clk);
      g++;
    end
    chk("rival_align_timeout", g < 5, 1);
    set_choice(ch, 1'b1);
    @(negedge clk);
    set_choice(ch, 1'b0);
    @(negedge clk);
    chk("select_before_accept", bus.selector, 1);
    @(negedge clk);
  endtask

  task automatic play(input rnd_t r);
    press_at_rival(r.choice, r.rival);
    for (int k = 0; k < 12; k++) begin
      bus.btn_rock = k == 1;
      chk("hold_sel", bus.selector, k < 4 ? r.exp_p : k < 8 ? 5 : r.exp_r);
      chk("hold_no_done", bus.round_done, 0);
      @(negedge clk);
    end
    chk("result_sel", bus.selector, r.exp_res);
    chk("result_wins", bus.wins, r.exp_w);
    chk("result_losses", bus.losses, r.exp_l);
    chk("done_pulse", bus.round_done, 1);
    @(negedge clk);
    chk("done_drop", bus.round_done, 0);
    chk("result_held", bus.selector, r.exp_res);
  endtask

  task automatic start_press();
    bus.btn_start = 1'b1;
    @(negedge clk);
    bus.btn_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("start_to_select", bus.selector, 1);
  endtask

  initial begin
    rnd_t r;
    tbl[0] = '{0, 2, 4, 3, 6, 1, 0};
    tbl[1] = '{1, 1, 2, 2, 8, 1, 0};
    tbl[2] = '{2, 0, 3, 4, 7, 1, 1};
    tbl[3] = '{1, 0, 2, 4, 6, 2, 1};
    tbl[4] = '{0, 1, 4, 2, 7, 2, 2};
    tbl[5] = '{2, 1, 3, 2, 6, 3, 2};
    {bus.btn_start, bus.btn_rock, bus.btn_paper, bus.btn_scissors} = '0;
    repeat (2) @(negedge clk);
    chk("reset_sel", bus.selector, 0);
    chk("reset_wins", bus.wins, 0);
    chk("reset_losses", bus.losses, 0);
    chk("reset_done", bus.round_done, 0);
    reset = 1'b1;
    @(negedge clk);
    bus.btn_start = 1'b1;
    @(negedge clk);
    bus.btn_start = 1'b0;
    chk("idle_edge1", bus.selector, 0);
    @(negedge clk);
    chk("idle_edge2", bus.selector, 0);
    @(negedge clk);
    chk("idle_edge3", bus.selector, 1);
    bus.btn_rock = 1'b1;
    bus.btn_paper = 1'b1;
    @(negedge clk);
    bus.btn_rock = 1'b0;
    bus.btn_paper = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("double_choice_ignored", bus.selector, 1);
    end
    for (int i = 0; i < 6; i++) begin
      play(tbl[i]);
      start_press();
    end
    for (int i = 0; i < 13; i++) begin
      r = '{0, 2, 4, 3, 6, (4 + i > 15) ? 15 : 4 + i, 2};
      play(r);
      start_press();
    end
    press_at_rival(0, 2);
    repeat (8) @(negedge clk);
    chk("in_show_rival", bus.selector, 3);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_sel", bus.selector, 0);
    chk("async_reset_wins", bus.wins, 0);
    chk("async_reset_losses", bus.losses, 0);
    chk("async_reset_done", bus.round_done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", bus.selector, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
